// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, NOP filler, default geometry.
package icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_FILL,
      ST_UPDATE
   } state_t;

   // addi x0, x0, 0 -- handed to ifetch whenever no real instruction is available
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int DEF_NB_LINES       = 16;
   localparam int DEF_WORDS_PER_LINE = 4;

endpackage

// File: rtl/icache_line_ram.sv
// Tag and data storage for the direct-mapped instruction cache.
// One write port per array, asynchronous read so a hit resolves in the lookup cycle.
module icache_line_ram #(
   parameter int NB_LINES       = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_W          = 24,
   localparam int IDX_W         = $clog2(NB_LINES),
   localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [OFF_W-1:0]  rd_offset,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [31:0]       rd_word,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [OFF_W-1:0]  wr_offset,
   input  logic              data_we,
   input  logic [31:0]       wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  wr_tag
);

   logic [31:0]      data_mem [NB_LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0] tag_mem  [NB_LINES];

   // NOTE: storage arrays carry no reset; the separate valid bits make stale contents harmless
   // and keep these mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (data_we)
         data_mem[{wr_index, wr_offset}] <= wr_data;
      if (tag_we)
         tag_mem[wr_index] <= wr_tag;
   end

   assign rd_word = data_mem[{rd_index, rd_offset}];
   assign rd_tag  = tag_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hits, fixed-length line refill
// from a request/ack/beat memory port, whole-cache flush for fence.i.
module icache
   import icache_pkg::*;
#(
   parameter int NB_LINES       = DEF_NB_LINES,
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ADR_SI,
   input  logic        ADR_VALID_SI,
   input  logic        IC_FLUSH_SI,
   output logic [31:0] IC_INST_SI,
   output logic        IC_STALL_SI,
   output logic [31:0] RAM_ADR_SC,
   output logic        RAM_REQ_SC,
   input  logic        RAM_ACK_SP,
   input  logic        RAM_VALID_SP,
   input  logic [31:0] RAM_DATA_SP
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NB_LINES);
   localparam int LSB_W = OFF_W + 2;
   localparam int TAG_W = 32 - IDX_W - LSB_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   state_t              state, state_n;
   logic [31:0]         line_adr;
   logic [OFF_W-1:0]    cnt;
   logic                flush_pending;
   logic [NB_LINES-1:0] valid;

   logic [OFF_W-1:0]    adr_offset;
   logic [IDX_W-1:0]    adr_index;
   logic [TAG_W-1:0]    adr_tag;
   logic [IDX_W-1:0]    line_index;
   logic [TAG_W-1:0]    line_tag;
   logic [TAG_W-1:0]    rd_tag;
   logic [31:0]         rd_word;
   logic                hit;
   logic                unused_adr_bits;

   logic capture, cnt_clr, cnt_inc, data_we, tag_we, set_valid, clear_all, set_flush;

   assign adr_offset      = ADR_SI[LSB_W-1:2];
   assign adr_index       = ADR_SI[IDX_W+LSB_W-1:LSB_W];
   assign adr_tag         = ADR_SI[31:IDX_W+LSB_W];
   assign line_index      = line_adr[IDX_W+LSB_W-1:LSB_W];
   assign line_tag        = line_adr[31:IDX_W+LSB_W];
   assign unused_adr_bits = ^ADR_SI[1:0];
   assign hit             = valid[adr_index] && (rd_tag == adr_tag);
   assign RAM_ADR_SC      = line_adr;

   icache_line_ram #(
      .NB_LINES       (NB_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W)
   ) u_line_ram (
      .clk       (clk),
      .rd_index  (adr_index),
      .rd_offset (adr_offset),
      .rd_tag    (rd_tag),
      .rd_word   (rd_word),
      .wr_index  (line_index),
      .wr_offset (cnt),
      .data_we   (data_we),
      .wr_data   (RAM_DATA_SP),
      .tag_we    (tag_we),
      .wr_tag    (line_tag)
   );

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned
   // and infer a latch.
   always_comb begin
      state_n     = state;
      IC_STALL_SI = 1'b0;
      IC_INST_SI  = NOP_INST;
      RAM_REQ_SC  = 1'b0;
      capture     = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      set_valid   = 1'b0;
      clear_all   = 1'b0;
      set_flush   = 1'b0;

      unique case (state)
         ST_IDLE: begin
            // A flush wins over the lookup: the hit is withheld and no refill starts this cycle.
            if (IC_FLUSH_SI) begin
               clear_all   = 1'b1;
               IC_STALL_SI = ADR_VALID_SI;
            end else if (ADR_VALID_SI) begin
               if (hit) begin
                  IC_INST_SI = rd_word;
               end else begin
                  IC_STALL_SI = 1'b1;
                  capture     = 1'b1;
                  state_n     = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            IC_STALL_SI = 1'b1;
            RAM_REQ_SC  = 1'b1;
            set_flush   = IC_FLUSH_SI;
            if (RAM_ACK_SP) begin
               cnt_clr = 1'b1;
               state_n = ST_FILL;
            end
         end
         ST_FILL: begin
            IC_STALL_SI = 1'b1;
            set_flush   = IC_FLUSH_SI;
            if (RAM_VALID_SP) begin
               data_we = 1'b1;
               cnt_inc = 1'b1;
               if (cnt == LAST_BEAT)
                  state_n = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            IC_STALL_SI = 1'b1;
            tag_we      = 1'b1;
            if (flush_pending || IC_FLUSH_SI)
               clear_all = 1'b1;
            else
               set_valid = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      if (reset) begin
         IC_STALL_SI = 1'b0;
         IC_INST_SI  = NOP_INST;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         line_adr      <= '0;
         cnt           <= '0;
         flush_pending <= 1'b0;
         valid         <= '0;
      end else begin
         state <= state_n;
         if (capture)
            line_adr <= {ADR_SI[31:LSB_W], {LSB_W{1'b0}}};
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + 1'b1;
         if (state == ST_UPDATE)
            flush_pending <= 1'b0;
         else if (set_flush)
            flush_pending <= 1'b1;
         if (clear_all)
            valid <= '0;
         else if (set_valid)
            valid[line_index] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: refills, hits, conflict eviction,
// flush in IDLE and mid-refill, reset mid-refill, slow ack with gapped beats.
module tb_icache;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ADR_SI;
   logic        ADR_VALID_SI;
   logic        IC_FLUSH_SI;
   logic [31:0] IC_INST_SI;
   logic        IC_STALL_SI;
   logic [31:0] RAM_ADR_SC;
   logic        RAM_REQ_SC;
   logic        RAM_ACK_SP;
   logic        RAM_VALID_SP;
   logic [31:0] RAM_DATA_SP;

   int checks = 0;
   int errors = 0;

   icache dut (
      .clk          (clk),
      .reset        (reset),
      .ADR_SI       (ADR_SI),
      .ADR_VALID_SI (ADR_VALID_SI),
      .IC_FLUSH_SI  (IC_FLUSH_SI),
      .IC_INST_SI   (IC_INST_SI),
      .IC_STALL_SI  (IC_STALL_SI),
      .RAM_ADR_SC   (RAM_ADR_SC),
      .RAM_REQ_SC   (RAM_REQ_SC),
      .RAM_ACK_SP   (RAM_ACK_SP),
      .RAM_VALID_SP (RAM_VALID_SP),
      .RAM_DATA_SP  (RAM_DATA_SP)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in IDLE with a missing address presented; returns in IDLE with the line written.
   task automatic do_refill(input logic [31:0] line, input logic [31:0] d0,
                            input int ack_dly, input int gap, input int flush_beat);
      logic [31:0] saved;
      check("miss_stall", {31'b0, IC_STALL_SI}, 32'd1);
      check("miss_noreq", {31'b0, RAM_REQ_SC}, 32'd0);
      saved = ADR_SI;
      tick();
      ADR_SI = 32'h0000_FFF0;
      #1;
      for (int c = 0; c < ack_dly; c++) begin
         check("req_held", {31'b0, RAM_REQ_SC}, 32'd1);
         check("req_adr", RAM_ADR_SC, line);
         check("req_stall", {31'b0, IC_STALL_SI}, 32'd1);
         tick();
      end
      RAM_ACK_SP = 1'b1;
      #1;
      check("ack_req", {31'b0, RAM_REQ_SC}, 32'd1);
      check("ack_adr", RAM_ADR_SC, line);
      tick();
      RAM_ACK_SP = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            #1;
            check("gap_stall", {31'b0, IC_STALL_SI}, 32'd1);
            check("gap_noreq", {31'b0, RAM_REQ_SC}, 32'd0);
            tick();
         end
         RAM_VALID_SP = 1'b1;
         RAM_DATA_SP  = d0 + 32'(i);
         IC_FLUSH_SI  = (i == flush_beat);
         #1;
         check("fill_stall", {31'b0, IC_STALL_SI}, 32'd1);
         tick();
         RAM_VALID_SP = 1'b0;
         IC_FLUSH_SI  = 1'b0;
      end
      ADR_SI = saved;
      #1;
      check("upd_stall", {31'b0, IC_STALL_SI}, 32'd1);
      check("upd_noreq", {31'b0, RAM_REQ_SC}, 32'd0);
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      ADR_SI       = 32'h100;
      ADR_VALID_SI = 1'b1;
      IC_FLUSH_SI  = 1'b0;
      RAM_ACK_SP   = 1'b0;
      RAM_VALID_SP = 1'b0;
      RAM_DATA_SP  = 32'h0;
      #2;
      check("rst_stall", {31'b0, IC_STALL_SI}, 32'd0);
      check("rst_inst", IC_INST_SI, 32'h13);
      check("rst_req", {31'b0, RAM_REQ_SC}, 32'd0);
      check("rst_adr", RAM_ADR_SC, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Cold miss on 0x100, then hit on word 0 and word 3.
      do_refill(32'h100, 32'hA0, 0, 0, -1);
      check("hit100_inst", IC_INST_SI, 32'hA0);
      check("hit100_stall", {31'b0, IC_STALL_SI}, 32'd0);
      ADR_SI = 32'h10C;
      #1;
      check("hit10c_inst", IC_INST_SI, 32'hA3);
      check("hit10c_stall", {31'b0, IC_STALL_SI}, 32'd0);
      check("hit10c_noreq", {31'b0, RAM_REQ_SC}, 32'd0);
      tick();
      check("hit10c_noreq2", {31'b0, RAM_REQ_SC}, 32'd0);

      // Conflict on index 0: 0x200 evicts 0x100.
      ADR_SI = 32'h200;
      #1;
      do_refill(32'h200, 32'hB0, 0, 0, -1);
      check("hit200_inst", IC_INST_SI, 32'hB0);
      ADR_SI = 32'h100;
      #1;
      check("evict100_inst", IC_INST_SI, 32'h13);

      // Slow memory: ack after 5 cycles, one idle cycle between beats.
      do_refill(32'h100, 32'hC0, 5, 1, -1);
      ADR_SI = 32'h104;
      #1;
      check("slow_inst", IC_INST_SI, 32'hC1);
      check("slow_stall", {31'b0, IC_STALL_SI}, 32'd0);

      // Flush during FILL beat 2: nothing stays valid.
      ADR_SI = 32'h200;
      #1;
      do_refill(32'h200, 32'hD0, 0, 0, 2);
      check("fl200_stall", {31'b0, IC_STALL_SI}, 32'd1);
      ADR_SI = 32'h100;
      #1;
      check("fl100_stall", {31'b0, IC_STALL_SI}, 32'd1);
      check("fl100_inst", IC_INST_SI, 32'h13);
      ADR_VALID_SI = 1'b0;
      #1;
      check("novalid_stall", {31'b0, IC_STALL_SI}, 32'd0);
      check("novalid_inst", IC_INST_SI, 32'h13);
      tick();

      // Flush in IDLE over a hit: stall that cycle, then the line is gone.
      ADR_VALID_SI = 1'b1;
      #1;
      do_refill(32'h100, 32'hE0, 0, 0, -1);
      check("hitE_inst", IC_INST_SI, 32'hE0);
      IC_FLUSH_SI = 1'b1;
      #1;
      check("idlefl_stall", {31'b0, IC_STALL_SI}, 32'd1);
      tick();
      IC_FLUSH_SI = 1'b0;
      #1;
      check("postfl_stall", {31'b0, IC_STALL_SI}, 32'd1);
      check("postfl_inst", IC_INST_SI, 32'h13);

      // Reset in the middle of a refill of 0x100.
      tick();
      check("rf_req", {31'b0, RAM_REQ_SC}, 32'd1);
      RAM_ACK_SP = 1'b1;
      tick();
      RAM_ACK_SP   = 1'b0;
      RAM_VALID_SP = 1'b1;
      RAM_DATA_SP  = 32'hF0;
      tick();
      RAM_DATA_SP  = 32'hF1;
      tick();
      RAM_VALID_SP = 1'b0;
      reset        = 1'b1;
      #1;
      check("mrst_req", {31'b0, RAM_REQ_SC}, 32'd0);
      check("mrst_stall", {31'b0, IC_STALL_SI}, 32'd0);
      check("mrst_inst", IC_INST_SI, 32'h13);
      check("mrst_adr", RAM_ADR_SC, 32'h0);
      ADR_VALID_SI = 1'b0;
      tick();
      reset        = 1'b0;
      RAM_VALID_SP = 1'b1;
      RAM_DATA_SP  = 32'hF2;
      tick();
      RAM_DATA_SP  = 32'hF3;
      #1;
      check("late_req", {31'b0, RAM_REQ_SC}, 32'd0);
      check("late_stall", {31'b0, IC_STALL_SI}, 32'd0);
      tick();
      RAM_VALID_SP = 1'b0;
      ADR_VALID_SI = 1'b1;
      ADR_SI       = 32'h100;
      #1;
      check("post_rst_miss", {31'b0, IC_STALL_SI}, 32'd1);
      check("post_rst_inst", IC_INST_SI, 32'h13);
      tick();
      check("post_rst_req", {31'b0, RAM_REQ_SC}, 32'd1);
      check("post_rst_adr", RAM_ADR_SC, 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
